// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in serial-out shifter with a power-of-two bit period.
//
// A word captured on an accepted load is shifted out MSB first, each bit held
// for 2^DIV_BITS clk cycles. busy marks the shifting interval, done pulses for
// one cycle after the last bit period, and ovr flags a load request made while
// a word was already in flight.
//
// Parameters
//   WIDTH     parallel word width in bits (>= 2)
//   DIV_BITS  log2 of the bit period in clk cycles (>= 1)
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   load  in   level-sampled request to start transmitting din
//   din   in   parallel word, sampled on an accepted load
//   sdo   out  serial data, MSB first; 0 while idle
//   busy  out  high while a word is being shifted out
//   done  out  one-cycle pulse after the final bit period
//   ovr   out  sticky: load requested while busy; cleared by rst or next accepted load
module piso_shifter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIV_BITS = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             sdo,
    output logic             busy,
    output logic             done,
    output logic             ovr
);

    localparam int unsigned   CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic                sdo_q, sdo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;
    // Set while the load level that started the current word is still held;
    // a continuously held load must not count as an overrun.
    logic                hold_q, hold_d;
    logic                tick_c;

    // End of a bit period: prescaler at its all-ones terminal value.
    assign tick_c = (state_q == SHIFT) && (&presc_q);

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ovr_d     = ovr_q;
        hold_d    = hold_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                if (load) begin
                    shreg_d   = din;
                    bit_cnt_d = '0;
                    ovr_d     = 1'b0;
                    hold_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                // Free-running; wraps to 0 at the end of each bit period.
                presc_d = presc_q + DIV_BITS'(1);
                // A fresh rising request (not the held one) is an overrun.
                if (load && !hold_q) begin
                    ovr_d = 1'b1;
                end
                hold_d = hold_q & load;
                if (tick_c) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase

        // Outputs registered from next-state values so they align with state_q.
        busy_d = (state_d == SHIFT);
        sdo_d  = (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            hold_q    <= hold_d;
        end
    end

    assign sdo  = sdo_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovr  = ovr_q;

endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: self-checking bench for piso_shifter (WIDTH=8, DIV_BITS=2).
// A behavioural model tracks, per accepted word, how many edges have elapsed
// since the load edge and derives sdo/busy/done/ovr from that count.
module tb_piso_shifter;

    localparam int W  = 8;
    localparam int DB = 2;
    localparam int BP = 4;        // cycles per bit
    localparam int WP = W * BP;   // cycles per word

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] din;
    logic         sdo, busy, done, ovr;

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(W), .DIV_BITS(DB)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (din),
        .sdo  (sdo),
        .busy (busy),
        .done (done),
        .ovr  (ovr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit           m_busy, m_done, m_ovr, m_hold;
    int           m_k;        // edges elapsed since the load edge
    logic [W-1:0] m_word;

    function automatic logic m_sdo();
        return m_busy ? m_word[W - 1 - m_k / BP] : 1'b0;
    endfunction

    // Drive inputs, clock one edge, update the model, settle 1 time unit.
    task automatic advance(input logic r, input logic ld, input logic [W-1:0] d);
        rst = r; load = ld; din = d;
        @(posedge clk);
        if (r) begin
            m_busy = 0; m_done = 0; m_ovr = 0; m_hold = 0; m_k = 0; m_word = '0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (ld) begin
                    m_busy = 1; m_k = 0; m_word = d; m_ovr = 0; m_hold = 1;
                end
            end else begin
                m_k++;
                if (ld && !m_hold) m_ovr = 1;
                m_hold = m_hold & ld;
                if (m_k == WP) begin
                    m_busy = 0; m_k = 0; m_done = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            advance(1'b1, 1'b1, 8'($urandom));
            checks++;
            if ({busy, sdo, done, ovr} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got {busy,sdo,done,ovr}=%b want 0000", i, {busy, sdo, done, ovr});
            end
        end
        // First edge after release with load high starts the word.
        advance(1'b0, 1'b1, 8'h5A);
        checks++;
        if ({busy, sdo} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got {busy,sdo}=%b want 10", {busy, sdo});
        end
        for (int n = 0; n < WP + 4; n++) begin
            advance(1'b0, 1'b0, 8'($urandom));
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL reset_drain n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] stream = '0;
        int busy_cnt = 0, done_at = -1;
        advance(1'b0, 1'b1, 8'hA5);
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) advance(1'b0, 1'b0, 8'($urandom));
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL basic n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
            if (busy) busy_cnt++;
            if (done) done_at = n;
            if (n <= WP && (n - 1) % BP == 0) stream = {stream[W-2:0], sdo};
        end
        checks++;
        if (stream !== 8'hA5) begin errors++; $display("FAIL basic_stream got %h want a5", stream); end
        checks++;
        if (busy_cnt != 32) begin errors++; $display("FAIL basic_busy_len got %0d want 32", busy_cnt); end
        checks++;
        if (done_at != 33) begin errors++; $display("FAIL basic_done_at got %0d want 33", done_at); end
    endtask

    task automatic test_din_change();
        logic [W-1:0] stream = '0;
        advance(1'b0, 1'b1, 8'h3C);
        for (int n = 1; n <= 36; n++) begin
            if (n > 1) advance(1'b0, 1'b0, 8'hFF);
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL din_change n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
            if (n <= WP && (n - 1) % BP == 0) stream = {stream[W-2:0], sdo};
        end
        checks++;
        if (stream !== 8'h3C) begin errors++; $display("FAIL din_change_stream got %h want 3c", stream); end
    endtask

    task automatic test_overrun();
        logic [W-1:0] stream = '0;
        advance(1'b0, 1'b1, 8'hC3);
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) advance(1'b0, n == 11, 8'($urandom));
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL overrun n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
            checks++;
            if (ovr !== (n >= 11)) begin
                errors++;
                $display("FAIL overrun_flag n=%0d got %b want %b", n, ovr, n >= 11);
            end
            if (n <= WP && (n - 1) % BP == 0) stream = {stream[W-2:0], sdo};
        end
        checks++;
        if (stream !== 8'hC3) begin errors++; $display("FAIL overrun_stream got %h want c3", stream); end
        advance(1'b0, 1'b1, 8'h0F);
        checks++;
        if ({busy, ovr} !== 2'b10) begin
            errors++;
            $display("FAIL overrun_clear got {busy,ovr}=%b want 10", {busy, ovr});
        end
        for (int n = 0; n < WP + 2; n++) advance(1'b0, 1'b0, 8'h00);
        checks++;
        if ({busy, sdo, ovr} !== 3'b000) begin
            errors++;
            $display("FAIL overrun_end got {busy,sdo,ovr}=%b want 000", {busy, sdo, ovr});
        end
    endtask

    task automatic test_hold();
        int done_cnt = 0, first_done = -1, second_rise = -1, rises = 0, ovr_seen = 0;
        logic prev_busy = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            advance(1'b0, 1'b1, 8'h81);
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL hold n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
            if (done) begin done_cnt++; if (first_done < 0) first_done = n; end
            if (busy && !prev_busy) begin rises++; if (rises == 2) second_rise = n; end
            if (ovr) ovr_seen++;
            prev_busy = busy;
        end
        checks++;
        if (done_cnt != 2) begin errors++; $display("FAIL hold_words got %0d want 2", done_cnt); end
        checks++;
        if (first_done != 33 || second_rise != 34) begin
            errors++;
            $display("FAIL hold_gap got done=%0d rise=%0d want 33 34", first_done, second_rise);
        end
        checks++;
        if (ovr_seen != 0) begin errors++; $display("FAIL hold_ovr got %0d cycles want 0", ovr_seen); end
        for (int n = 0; n < WP + 4; n++) begin
            advance(1'b0, 1'b0, 8'($urandom));
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL hold_drain n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        logic [W-1:0] stream = '0;
        advance(1'b0, 1'b1, 8'hE7);
        for (int n = 2; n <= 12; n++) advance(1'b0, 1'b0, 8'($urandom));
        advance(1'b1, 1'b0, 8'($urandom));
        checks++;
        if ({busy, sdo, done, ovr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got {busy,sdo,done,ovr}=%b want 0000", {busy, sdo, done, ovr});
        end
        for (int n = 0; n < WP + 4; n++) begin
            advance(1'b0, 1'b0, 8'($urandom));
            if (done || busy) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", done_cnt); end
        advance(1'b0, 1'b1, 8'h01);
        for (int n = 1; n <= 34; n++) begin
            if (n > 1) advance(1'b0, 1'b0, 8'($urandom));
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL reset_mid_word n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
            if (n <= WP && (n - 1) % BP == 0) stream = {stream[W-2:0], sdo};
        end
        checks++;
        if (stream !== 8'h01) begin errors++; $display("FAIL reset_mid_stream got %h want 01", stream); end
    endtask

    task automatic test_back_to_back();
        advance(1'b0, 1'b1, 8'h66);
        for (int n = 2; n <= 33; n++) advance(1'b0, 1'b0, 8'h00);
        checks++;
        if ({busy, sdo, done} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_gap got {busy,sdo,done}=%b want 001", {busy, sdo, done});
        end
        advance(1'b0, 1'b1, 8'h99);
        checks++;
        if ({busy, sdo, done, ovr} !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_start got {busy,sdo,done,ovr}=%b want 1100", {busy, sdo, done, ovr});
        end
        for (int n = 0; n < WP + 2; n++) begin
            advance(1'b0, 1'b0, 8'($urandom));
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL b2b n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
        end
    endtask

    task automatic test_random();
        logic ld = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) ld = ~ld;
            advance($urandom_range(0, 199) == 0, ld, 8'($urandom));
            checks++;
            if ({busy, sdo, done, ovr} !== {m_busy, m_sdo(), m_done, m_ovr}) begin
                errors++;
                $display("FAIL random n=%0d got %b want %b", n, {busy, sdo, done, ovr}, {m_busy, m_sdo(), m_done, m_ovr});
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; din = '0;
        m_busy = 0; m_done = 0; m_ovr = 0; m_hold = 0; m_k = 0; m_word = '0;
        test_reset();
        test_basic();
        test_din_change();
        test_overrun();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
